layer1_pool: RTL
================

Name: layer1_pool

Overview:
- Sits directly downstream of the layer-0 convolution stage.
- Consumes its result stream (valid + 19-bit data).
- Writes every result unchanged, zero-extended to 20 bits, to the L0 memory write port.
- Computes 2x2 stride-2 max-pooling on the fly and writes the 32x32 result to the L1 memory write port.
- Uses a half-row line buffer, so no read-back of L0 memory is needed.

Parameters:
- IMG_W, 64, image width and height in pixels; power of two, ≥4.
- DATA_W, 19, input result width.
- MEM_W, 20, memory word width; must be > DATA_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- i_start  input  1  one-cycle pulse; arms a new frame
- i_valid  input  1  input result valid (no backpressure)
- i_data  input  DATA_W  conv result, raster order (row-major, col 0..IMG_W-1)
- o_busy  output  1  high from i_start until frame done
- o_l0_we  output  1  L0 write strobe
- o_l0_addr  output  log2(IMG_W*IMG_W)  L0 address = {row, col}
- o_l0_data  output  MEM_W  zero-extended result
- o_l1_we  output  1  L1 write strobe
- o_l1_addr  output  log2(IMG_W*IMG_W/4)  L1 address = {row>>1, col>>1}
- o_l1_data  output  MEM_W  pooled max, zero-extended
- o_done  output  1  one-cycle pulse after the last L1 write

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; row, col, temp reg and all line-buffer entries cleared.
  - All outputs 0.
- States: IDLE, RUN, DONE.
  - IDLE: i_valid ignored; i_start -> RUN, o_busy=1 next cycle, counters zeroed.
  - RUN: each i_valid beat is one pixel at (row, col); col increments, wraps at IMG_W-1 and row increments.
  - RUN -> DONE: registered on the beat at row=col=IMG_W-1.
  - DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE.
  - i_start while busy: ignored.
- L0 path:
  - Latency 1: beat at cycle t -> o_l0_we=1 at t+1 with that beat's address and data.
  - o_l0_we=0 on cycles after a non-valid cycle.
- Pool path:
  - Even col: temp <= pixel.
  - Odd col, even row: lbuf[col>>1] <= max(temp, pixel).
  - Odd col, odd row: o_l1_data <= max(temp, pixel, lbuf[col>>1]), o_l1_we=1 next cycle.
  - Comparison: unsigned DATA_W-bit (see optional feature).
  - Line buffer: IMG_W/2 entries x DATA_W; each entry written once per row pair and read once per row pair; no clear needed between row pairs.
- Timing:
  - The final L0 and L1 writes share the cycle after the last beat.
  - o_done asserts in that same cycle.
- Gaps: idle cycles between valid beats are allowed anywhere, including mid-row; state is preserved.
- Reset mid-frame: immediate return to IDLE, no partial-frame o_done, any pending write strobe dropped.
- Counter wrap: exactly IMG_W*IMG_W beats per frame; beats after DONE until the next i_start are ignored.

Optional Feature:
- Macro LAYER1_RELU_EN.
- Defined:
  - i_data is treated as signed two's complement; negative values clamp to 0 before both the L0 write and pooling.
  - Max comparison operates on the clamped non-negative values.
- Undefined:
  - i_data is treated as unsigned, which is valid when the upstream stage already applies ReLU.
  - No clamping logic is instantiated.

Decomposition:
- Shared package/header holds:
  - IMG_W, DATA_W, MEM_W;
  - L0/L1 address widths;
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: pool_linebuf (IMG_W/2-entry register-file line buffer, one write port, one read port, indexed by col>>1).
- Comparator and counters stay in the top module.

Test Plan:
- Reset/idle:
  - Stimulus: reset low 2 cycles, then i_valid=1 with no i_start.
  - Required: all outputs 0, no writes, o_busy=0.
- Ramp frame:
  - Stimulus: i_start, then 4096 back-to-back beats with pixel = row*64+col.
  - Required: L0[a]=a for all a; L1[{r,c}] = (2r+1)*64+2c+1; o_done exactly once, the cycle after beat 4095.
- Max position:
  - Stimulus: 2x2 block (0,0),(0,1),(1,0),(1,1) set to {5,9,3,7}; all else 0.
  - Required: L1[0]=9.
  - Repeat with the max in each of the four positions: L1[0] always 9.
- Gapped input:
  - Stimulus: insert 1–3 random idle cycles between beats.
  - Required: L0/L1 contents identical to the back-to-back run; write count 4096 L0 and 1024 L1.
- Reset mid-frame:
  - Stimulus: reset low at beat 2000, then i_start and a full ramp frame.
  - Required: no o_done from the aborted frame; second frame correct.
- RELU:
  - Stimulus: with LAYER1_RELU_EN, pixel 19'h7FFFF (-1) next to 2.
  - Required: L0 data 0 for the negative pixel; L1 max = 2.
  - Without the macro: L1 max = 20'h7FFFF.

Source files
------------

// File: rtl/layer1_pool_pkg.sv
// Shared constants, FSM encoding and small helpers for the layer-1 pooling stage.
package layer1_pool_pkg;

    localparam int unsigned IMG_W    = 64;
    localparam int unsigned DATA_W   = 19;
    localparam int unsigned MEM_W    = 20;
    localparam int unsigned CNT_W    = $clog2(IMG_W);
    localparam int unsigned L0_AW    = 2 * CNT_W;
    localparam int unsigned L1_AW    = 2 * (CNT_W - 1);
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LB_AW    = CNT_W - 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [MEM_W-1:0] zext(input logic [DATA_W-1:0] v);
        return {{(MEM_W - DATA_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/layer1_pool_linebuf.sv
// Half-row line buffer: holds the even-row pair maxima until the odd row consumes them.
module layer1_pool_linebuf
    import layer1_pool_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [LB_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [LB_AW-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [LB_DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer1_pool.sv
// Writes each conv result to L0 and a 2x2 stride-2 max-pooled image to L1.
// Define LAYER1_RELU_EN to treat i_data as signed and clamp negatives to zero.
module layer1_pool
    import layer1_pool_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_l0_we,
    output logic [L0_AW-1:0]  o_l0_addr,
    output logic [MEM_W-1:0]  o_l0_data,
    output logic              o_l1_we,
    output logic [L1_AW-1:0]  o_l1_addr,
    output logic [MEM_W-1:0]  o_l1_data,
    output logic              o_done
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  row_q, col_q;
    logic [DATA_W-1:0] temp_q;
    logic              busy_q, done_q;
    logic              l0_we_q, l1_we_q;
    logic [L0_AW-1:0]  l0_addr_q;
    logic [L1_AW-1:0]  l1_addr_q;
    logic [MEM_W-1:0]  l0_data_q, l1_data_q;

    logic [DATA_W-1:0] pix, pair_max, lb_rdata;
    logic              beat, last_beat, lb_we;

`ifdef LAYER1_RELU_EN
    assign pix = i_data[DATA_W-1] ? '0 : i_data;
`else
    assign pix = i_data;
`endif

    assign beat      = (state_q == StRun) && i_valid;
    assign last_beat = (row_q == CntMax) && (col_q == CntMax);
    assign pair_max  = max2(temp_q, pix);
    assign lb_we     = beat && col_q[0] && !row_q[0];

    layer1_pool_linebuf u_linebuf (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (lb_we),
        .waddr_i (col_q[CNT_W-1:1]),
        .wdata_i (pair_max),
        .raddr_i (col_q[CNT_W-1:1]),
        .rdata_o (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            temp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            l0_we_q   <= 1'b0;
            l1_we_q   <= 1'b0;
            l0_addr_q <= '0;
            l1_addr_q <= '0;
            l0_data_q <= '0;
            l1_data_q <= '0;
        end else begin
            l0_we_q <= 1'b0;
            l1_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                StRun: begin
                    if (i_valid) begin
                        l0_we_q   <= 1'b1;
                        l0_addr_q <= {row_q, col_q};
                        l0_data_q <= zext(pix);
                        if (!col_q[0]) begin
                            temp_q <= pix;
                        end else if (row_q[0]) begin
                            l1_we_q   <= 1'b1;
                            l1_addr_q <= {row_q[CNT_W-1:1], col_q[CNT_W-1:1]};
                            l1_data_q <= zext(max2(pair_max, lb_rdata));
                        end
                        col_q <= col_q + CntOne;
                        if (col_q == CntMax) begin
                            row_q <= row_q + CntOne;
                        end
                        if (last_beat) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_l0_we   = l0_we_q;
    assign o_l0_addr = l0_addr_q;
    assign o_l0_data = l0_data_q;
    assign o_l1_we   = l1_we_q;
    assign o_l1_addr = l1_addr_q;
    assign o_l1_data = l1_data_q;

endmodule
